// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronizes and deglitches the raw keyboard pins, deframes
// 11-bit frames and delivers scan-code bytes with an optional E0 prefix flag.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter bit STRIP_E0   = 1'b1
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2data,
    output logic       ps2hit,
    output logic       ps2ext,
    output logic       ps2err
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic              clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_clk, filt_clk_d;
    logic              strobe;

    state_t            state, state_nxt;
    logic [2:0]        bitcnt, bitcnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic              par_ok, par_ok_nxt;
    logic              ext_pend, ext_pend_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;
    logic [7:0]        data_nxt;
    logic              hit_nxt, ext_nxt, err_nxt;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock only follows a level that has persisted FILTER_LEN cycles.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FCNT_MAX) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign strobe = filt_clk_d & ~filt_clk;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            ext_pend <= 1'b0;
            tcnt     <= '0;
            ps2data  <= '0;
            ps2hit   <= 1'b0;
            ps2ext   <= 1'b0;
            ps2err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bitcnt   <= bitcnt_nxt;
            shreg    <= shreg_nxt;
            par_ok   <= par_ok_nxt;
            ext_pend <= ext_pend_nxt;
            tcnt     <= tcnt_nxt;
            ps2data  <= data_nxt;
            ps2hit   <= hit_nxt;
            ps2ext   <= ext_nxt;
            ps2err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bitcnt_nxt   = bitcnt;
        shreg_nxt    = shreg;
        par_ok_nxt   = par_ok;
        ext_pend_nxt = ext_pend;
        tcnt_nxt     = tcnt;
        data_nxt     = ps2data;
        ext_nxt      = ps2ext;
        hit_nxt      = 1'b0;
        err_nxt      = 1'b0;

        // A strobe in the same cycle always beats the timeout.
        if (state == IDLE || strobe) begin
            tcnt_nxt = '0;
        end else if (tcnt == TCNT_MAX) begin
            tcnt_nxt     = '0;
            state_nxt    = IDLE;
            err_nxt      = 1'b1;
            ext_pend_nxt = 1'b0;
        end else begin
            tcnt_nxt = tcnt + 1'b1;
        end

        if (strobe) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_nxt  = DATA;
                        bitcnt_nxt = '0;
                    end
                end
                DATA: begin
                    shreg_nxt  = {dat_s2, shreg[7:1]};
                    bitcnt_nxt = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_nxt = ^{shreg, dat_s2};
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (dat_s2 && par_ok) begin
                        if (STRIP_E0 && shreg == 8'hE0) begin
                            ext_pend_nxt = 1'b1;
                        end else begin
                            hit_nxt      = 1'b1;
                            data_nxt     = shreg;
                            ext_nxt      = ext_pend;
                            // F0 keeps the pending prefix so E0 F0 xx flags both bytes.
                            ext_pend_nxt = (shreg == 8'hF0) ? ext_pend : 1'b0;
                        end
                    end else begin
                        err_nxt      = 1'b1;
                        ext_pend_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
